// File: rtl/inst_queue.sv
// inst_queue
//   Multi-issue instruction queue between fetch and decode/rename.
//   Each cycle it accepts up to FETCH_NUM {inst, pc} pairs under a sparse lane
//   mask and packs them in program order into a circular array. It presents
//   the ISSUE_NUM oldest entries to decode, which retires 0..ISSUE_NUM per cycle.
//
// Ports
//   clk        clock, all state changes on rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous flush; wins over enqueue and dequeue
//   in_valid   fetch group offered
//   in_mask    per-lane valid, any pattern
//   in_inst    lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_pc      lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   in_ready   room for a full FETCH_NUM group (registered count only)
//   out_valid  thermometer, bit k = (count > k)
//   out_inst   lane k = k-th oldest instruction
//   out_pc     lane k = k-th oldest PC
//   deq_num    entries consumed this cycle, clamped to occupancy and ISSUE_NUM
//   count      occupancy 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
module inst_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int FETCH_NUM  = 4,
  parameter int ISSUE_NUM  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              in_valid,
  input  logic [FETCH_NUM-1:0]              in_mask,
  input  logic [FETCH_NUM*DATA_WIDTH-1:0]   in_inst,
  input  logic [FETCH_NUM*ADDR_WIDTH-1:0]   in_pc,
  output logic                              in_ready,
  output logic [ISSUE_NUM-1:0]              out_valid,
  output logic [ISSUE_NUM*DATA_WIDTH-1:0]   out_inst,
  output logic [ISSUE_NUM*ADDR_WIDTH-1:0]   out_pc,
  input  logic [$clog2(ISSUE_NUM+1)-1:0]    deq_num,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              empty,
  output logic                              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  // One extra bit so count + n_in - n_out never wraps in the intermediate sum.
  localparam int EXT_W = CNT_W + 1;

  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [EXT_W-1:0] n_in;
  logic [EXT_W-1:0] n_out;
  logic [EXT_W-1:0] count_ext;
  logic [PTR_W-1:0] lane_off [FETCH_NUM];
  logic             enq_fire;

  // Storage is deliberately not reset; only the pointers/count define validity.
  logic [DATA_WIDTH-1:0] mem_inst [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];

  // Compaction: a set lane's slot offset is the number of set lanes below it.
  always_comb begin
    n_in = '0;
    for (int i = 0; i < FETCH_NUM; i++) begin
      lane_off[i] = PTR_W'(n_in);
      n_in        = n_in + EXT_W'(in_mask[i]);
    end
  end

  assign in_ready = ({1'b0, count_q} + EXT_W'(FETCH_NUM)) <= EXT_W'(DEPTH);
  assign enq_fire = in_valid & in_ready & (|in_mask) & ~clr;

  always_comb begin
    n_out = EXT_W'(deq_num);
    if (n_out > {1'b0, count_q})     n_out = {1'b0, count_q};
    if (n_out > EXT_W'(ISSUE_NUM))   n_out = EXT_W'(ISSUE_NUM);
  end

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    count_d   = count_q;
    count_ext = {1'b0, count_q} + (enq_fire ? n_in : '0) - n_out;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (enq_fire) w_ptr_d = w_ptr_q + PTR_W'(n_in);
      r_ptr_d = r_ptr_q + PTR_W'(n_out);
      count_d = CNT_W'(count_ext);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

  // Pointer arithmetic is PTR_W bits wide, so slots wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < FETCH_NUM; i++) begin
        if (in_mask[i]) begin
          mem_inst[w_ptr_q + lane_off[i]] <= in_inst[i*DATA_WIDTH +: DATA_WIDTH];
          mem_pc[w_ptr_q + lane_off[i]]   <= in_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int k = 0; k < ISSUE_NUM; k++) begin
      out_valid[k]                        = count_q > CNT_W'(k);
      out_inst[k*DATA_WIDTH +: DATA_WIDTH] = mem_inst[r_ptr_q + PTR_W'(k)];
      out_pc[k*ADDR_WIDTH +: ADDR_WIDTH]   = mem_pc[r_ptr_q + PTR_W'(k)];
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic [3:0]   in_mask;
  logic [127:0] in_inst;
  logic [127:0] in_pc;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [127:0] out_inst;
  logic [127:0] out_pc;
  logic [2:0]   deq_num;
  logic [5:0]   count;
  logic         empty;
  logic         full;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of {inst, pc}; front is the oldest entry.
  logic [63:0] mq[$];
  // PCs actually presented by the DUT on lanes that the model says were consumed.
  logic [31:0] dut_popped[$];

  inst_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .FETCH_NUM(4), .ISSUE_NUM(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_mask(in_mask),
    .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .deq_num(deq_num), .count(count),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] ov;
    ov = '0;
    for (int k = 0; k < 4; k++) ov[k] = (mq.size() > k);
    check({tag, ".count"}, 64'(count), 64'(mq.size()));
    check({tag, ".empty"}, 64'(empty), 64'(mq.size() == 0));
    check({tag, ".full"}, 64'(full), 64'(mq.size() == 32));
    check({tag, ".in_ready"}, 64'(in_ready), 64'((32 - mq.size()) >= 4));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    for (int k = 0; k < 4; k++) begin
      if (k < mq.size()) begin
        check({tag, ".out_pc"}, 64'(out_pc[k*32 +: 32]), 64'(mq[k][31:0]));
        check({tag, ".out_inst"}, 64'(out_inst[k*32 +: 32]), 64'(mq[k][63:32]));
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] m, input logic [2:0] d,
                      input logic c, input logic [127:0] insts, input logic [127:0] pcs);
    int  n_out;
    bit  rdy;
    in_valid = v; in_mask = m; deq_num = d; clr = c; in_inst = insts; in_pc = pcs;
    rdy = (32 - mq.size()) >= 4;
    if (c) begin
      mq.delete();
    end else begin
      n_out = int'(d);
      if (n_out > mq.size()) n_out = mq.size();
      if (n_out > 4) n_out = 4;
      for (int k = 0; k < n_out; k++) dut_popped.push_back(out_pc[k*32 +: 32]);
      repeat (n_out) void'(mq.pop_front());
      if (v && rdy && m != 4'b0)
        for (int i = 0; i < 4; i++)
          if (m[i]) mq.push_back({insts[i*32 +: 32], pcs[i*32 +: 32]});
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  function automatic logic [127:0] seq_pcs(input logic [31:0] base);
    return {base + 32'd12, base + 32'd8, base + 32'd4, base};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [31:0] next_pc;
  logic [127:0] pcs;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_mask = '0; deq_num = '0;
    in_inst = '0; in_pc = '0;
    #22 rst = 1'b0;
    check_all("reset");

    // Full group, then drain it.
    step("enq4", 1, 4'b1111, 0, 0, rnd128(), seq_pcs(32'h8000_0000));
    check("enq4.lane0", 64'(out_pc[31:0]), 64'h8000_0000);
    check("enq4.lane3", 64'(out_pc[127:96]), 64'h8000_000C);
    step("deq4", 0, 4'b0000, 4, 0, rnd128(), rnd128());

    // Sparse mask packs lanes 1 and 3 into slots 0 and 1.
    step("sparse", 1, 4'b1010, 0, 0, rnd128(), {32'h10C, 32'hDEAD, 32'h104, 32'hBEEF});
    check("sparse.lane0", 64'(out_pc[31:0]), 64'h104);
    check("sparse.lane1", 64'(out_pc[63:32]), 64'h10C);
    step("sparse_drain", 0, 4'b0000, 7, 0, rnd128(), rnd128());

    // Fill to full, offered group ignored, one dequeue reopens in_ready.
    for (int g = 0; g < 8; g++) step("fill", 1, 4'b1111, 0, 0, rnd128(), rnd128());
    check("fill.full", 64'(full), 64'd1);
    step("full_ignore", 1, 4'b1111, 0, 0, rnd128(), rnd128());
    step("full_deq", 0, 4'b0000, 4, 0, rnd128(), rnd128());
    check("full_deq.ready", 64'(in_ready), 64'd1);
    for (int g = 0; g < 8; g++) step("drain", 0, 4'b0000, 4, 0, rnd128(), rnd128());
    step("empty_deq", 0, 4'b0000, 4, 0, rnd128(), rnd128());

    // Wrap-around stream: pointers run around the array several times.
    dut_popped.delete();
    next_pc = 32'h0000_1000;
    for (int c = 0; c < 23; c++) begin
      pcs = seq_pcs(next_pc);
      next_pc = next_pc + 32'd16;
      step("wrap", 1, 4'b1111, (c < 3) ? 3'd0 : 3'd4, 0, rnd128(), pcs);
    end
    for (int g = 0; g < 4; g++) step("wrap_drain", 0, 4'b0000, 4, 0, rnd128(), rnd128());
    check("wrap.n_popped", 64'(dut_popped.size()), 64'd92);
    for (int i = 0; i < dut_popped.size(); i++)
      check("wrap.stream", 64'(dut_popped[i]), 64'(32'h0000_1000 + 32'(i) * 32'd4));

    // Clamped dequeue with simultaneous enqueue.
    step("cnt2", 1, 4'b0011, 0, 0, rnd128(), seq_pcs(32'h2000));
    step("clamp", 1, 4'b1111, 4, 0, rnd128(), seq_pcs(32'h3000));
    check("clamp.count", 64'(count), 64'd4);
    check("clamp.lane0", 64'(out_pc[31:0]), 64'h3000);
    step("clamp_drain", 0, 4'b0000, 4, 0, rnd128(), rnd128());

    // Flush beats a same-cycle enqueue.
    step("c10a", 1, 4'b1111, 0, 0, rnd128(), rnd128());
    step("c10b", 1, 4'b1111, 0, 0, rnd128(), rnd128());
    step("c10c", 1, 4'b0110, 0, 0, rnd128(), rnd128());
    check("c10.count", 64'(count), 64'd10);
    step("clr", 1, 4'b1111, 4, 1, rnd128(), rnd128());
    check("clr.empty", 64'(empty), 64'd1);

    // Async reset between edges.
    step("pre_rst", 1, 4'b1111, 0, 0, rnd128(), rnd128());
    step("pre_rst2", 1, 4'b1011, 1, 0, rnd128(), rnd128());
    #2 rst = 1'b1;
    mq.delete();
    #1 check_all("async_rst");
    #2 rst = 1'b0;

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 40) == 0), rnd128(), rnd128());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
